// File: rtl/histogram_pkg.sv
// histogram_pkg: shared histogram sizing defaults and CDF state encoding
package histogram_pkg;
  localparam int HIST_NUM_BINS = 256;
  localparam int HIST_BIN_ADDR_WIDTH = 8;
  localparam int HIST_COUNT_WIDTH = 16;
  localparam int HIST_READ_LATENCY = 2;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    DRAIN = 2'b10,
    DONE  = 2'b11
  } cdf_state_t;
endpackage

// File: rtl/histogram_cdf_read_pipe.sv
// histogram_cdf_read_pipe: valid+address delay line matching the scratch memory read latency
module histogram_cdf_read_pipe #(
  parameter int DEPTH = 2,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [ADDR_WIDTH-1:0] issue_address,
  output logic                  return_valid,
  output logic [ADDR_WIDTH-1:0] return_address
);
  logic [DEPTH-1:0] valid_q;
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      valid_q[0] <= issue_valid;
      addr_q[0] <= issue_address;
      for (int i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  assign return_valid = valid_q[DEPTH-1];
  assign return_address = addr_q[DEPTH-1];
endmodule

// File: rtl/histogram_cdf.sv
// histogram_cdf: streams histogram bins from scratch memory and writes the running saturated CDF
module histogram_cdf
  import histogram_pkg::*;
#(
  parameter int NUM_BINS = HIST_NUM_BINS,
  parameter int BIN_ADDR_WIDTH = HIST_BIN_ADDR_WIDTH,
  parameter int COUNT_WIDTH = HIST_COUNT_WIDTH,
  parameter int READ_LATENCY = HIST_READ_LATENCY
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start_cdf,
  output logic                      scratch_mem_read_enable,
  output logic [BIN_ADDR_WIDTH-1:0] scratch_mem_read_address,
  input  logic [COUNT_WIDTH-1:0]    scratch_mem_read_data,
  output logic                      cdf_mem_write_enable,
  output logic [BIN_ADDR_WIDTH-1:0] cdf_mem_write_address,
  output logic [COUNT_WIDTH-1:0]    cdf_mem_write_data,
  output logic [COUNT_WIDTH-1:0]    cdf_min,
  output logic [COUNT_WIDTH-1:0]    cdf_total,
  output logic                      cdf_overflow,
  output logic                      cdf_busy,
  output logic                      cdf_computation_done
);
  localparam logic [BIN_ADDR_WIDTH-1:0] LAST_BIN = BIN_ADDR_WIDTH'(NUM_BINS - 1);
  cdf_state_t state;
  logic [COUNT_WIDTH-1:0] sum;
  logic [COUNT_WIDTH-1:0] new_sum;
  logic [COUNT_WIDTH:0] sum_ext;
  logic min_found;
  logic pipe_valid;
  logic [BIN_ADDR_WIDTH-1:0] pipe_address;
  histogram_cdf_read_pipe #(
    .DEPTH(READ_LATENCY),
    .ADDR_WIDTH(BIN_ADDR_WIDTH)
  ) u_read_pipe (
    .clock(clock),
    .reset(reset),
    .issue_valid(scratch_mem_read_enable),
    .issue_address(scratch_mem_read_address),
    .return_valid(pipe_valid),
    .return_address(pipe_address)
  );
  always_comb begin
    sum_ext = {1'b0, sum} + {1'b0, scratch_mem_read_data};
    new_sum = sum_ext[COUNT_WIDTH] ? '1 : sum_ext[COUNT_WIDTH-1:0];
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      scratch_mem_read_enable <= 1'b0;
      scratch_mem_read_address <= '0;
      cdf_mem_write_enable <= 1'b0;
      cdf_mem_write_address <= '0;
      cdf_mem_write_data <= '0;
      cdf_min <= '0;
      cdf_total <= '0;
      cdf_overflow <= 1'b0;
      cdf_busy <= 1'b0;
      cdf_computation_done <= 1'b0;
      sum <= '0;
      min_found <= 1'b0;
    end else begin
      cdf_mem_write_enable <= pipe_valid;
      cdf_computation_done <= 1'b0;
      if (pipe_valid) begin
        sum <= new_sum;
        cdf_mem_write_address <= pipe_address;
        cdf_mem_write_data <= new_sum;
        cdf_total <= new_sum;
        if (sum_ext[COUNT_WIDTH]) cdf_overflow <= 1'b1;
        if (!min_found && new_sum != '0) begin
          cdf_min <= new_sum;
          min_found <= 1'b1;
        end
      end
      case (state)
        IDLE:
          if (start_cdf) begin
            state <= ISSUE;
            scratch_mem_read_enable <= 1'b1;
            scratch_mem_read_address <= '0;
            cdf_busy <= 1'b1;
            sum <= '0;
            cdf_min <= '0;
            cdf_total <= '0;
            cdf_overflow <= 1'b0;
            min_found <= 1'b0;
          end
        ISSUE:
          if (scratch_mem_read_address == LAST_BIN) begin
            scratch_mem_read_enable <= 1'b0;
            state <= DRAIN;
          end else scratch_mem_read_address <= scratch_mem_read_address + 1'b1;
        DRAIN:
          if (cdf_mem_write_enable && cdf_mem_write_address == LAST_BIN) begin
            state <= DONE;
            cdf_computation_done <= 1'b1;
          end
        DONE: begin
          state <= IDLE;
          cdf_busy <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_histogram_cdf.sv
// tb_histogram_cdf: directed table-driven bench for histogram_cdf at read latencies 1, 2 and 4
module tb_histogram_cdf;
  localparam int LAT [3] = '{1, 2, 4};
  typedef struct {
    int kind;
    int e_min;
    int e_tot;
    int e_ovf;
    int k0;
    int e0;
    int k1;
    int e1;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start_cdf = 1'b0;
  always #5 clock = ~clock;
  logic [15:0] mem [256];
  logic re [3];
  logic we [3];
  logic covf [3];
  logic busy [3];
  logic done [3];
  logic [7:0] ra [3];
  logic [7:0] wa [3];
  logic [15:0] rd [3];
  logic [15:0] wd [3];
  logic [15:0] cmin [3];
  logic [15:0] ctot [3];
  logic [7:0] dl [3][4];
  logic [15:0] got [3][256];
  int nwr [3];
  int nxt [3];
  int aerr [3];
  int ndone [3];
  int s_edge [3];
  int d_edge [3];
  int edges = 0;
  int n_cmp = 0;
  int n_err = 0;
  vec_t vt [4];
  for (genvar g = 0; g < 3; g++) begin : g_dut
    histogram_cdf #(.READ_LATENCY(LAT[g])) u_dut (
      .clock(clock),
      .reset(reset),
      .start_cdf(start_cdf),
      .scratch_mem_read_enable(re[g]),
      .scratch_mem_read_address(ra[g]),
      .scratch_mem_read_data(rd[g]),
      .cdf_mem_write_enable(we[g]),
      .cdf_mem_write_address(wa[g]),
      .cdf_mem_write_data(wd[g]),
      .cdf_min(cmin[g]),
      .cdf_total(ctot[g]),
      .cdf_overflow(covf[g]),
      .cdf_busy(busy[g]),
      .cdf_computation_done(done[g])
    );
  end
  always @(posedge clock) begin
    edges <= edges + 1;
    for (int i = 0; i < 3; i++) begin
      dl[i][0] <= ra[i];
      for (int j = 1; j < 4; j++) dl[i][j] <= dl[i][j-1];
    end
  end
  always_comb for (int i = 0; i < 3; i++) rd[i] = mem[dl[i][LAT[i]-1]];
  always @(negedge clock)
    for (int i = 0; i < 3; i++) begin
      if (re[i] && ra[i] == 8'd0) begin
        nwr[i] = 0;
        nxt[i] = 0;
        aerr[i] = 0;
        ndone[i] = 0;
        s_edge[i] = edges;
      end
      if (we[i]) begin
        got[i][wa[i]] = wd[i];
        if (int'(wa[i]) != nxt[i]) aerr[i]++;
        nxt[i]++;
        nwr[i]++;
      end
      if (done[i]) begin
        ndone[i]++;
        d_edge[i] = edges;
      end
    end
  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
    end
  endtask
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic fill(input int kind);
    for (int k = 0; k < 256; k++)
      mem[k] = kind == 0 ? 16'd1 : kind == 1 ? (k == 10 ? 16'd5 : k == 255 ? 16'd3 : 16'd0) :
               kind == 2 ? 16'h0200 : 16'd0;
  endtask
  task automatic pulse();
    start_cdf = 1'b1;
    tick(1);
    start_cdf = 1'b0;
  endtask
  task automatic wait_done(input int i, input int rep);
    int t = 0;
    while (ndone[i] == 0 && t < 400) begin
      tick(1);
      t++;
      if (t == rep) start_cdf = 1'b1;
      if (t == rep + 1) start_cdf = 1'b0;
    end
    if (ndone[i] == 0) chk("done_timeout", 0, 1);
    tick(3);
  endtask
  task automatic check_pass(input vec_t v);
    for (int i = 0; i < 3; i++) begin
      int s = 0;
      int mism = 0;
      for (int k = 0; k < 256; k++) begin
        s = s + int'(mem[k]);
        if (s > 65535) s = 65535;
        if (int'(got[i][k]) != s) mism++;
      end
      chk($sformatf("writes_L%0d", LAT[i]), nwr[i], 256);
      chk($sformatf("addr_order_L%0d", LAT[i]), aerr[i], 0);
      chk($sformatf("done_pulses_L%0d", LAT[i]), ndone[i], 1);
      chk($sformatf("done_cycle_L%0d", LAT[i]), d_edge[i] - s_edge[i] + 1, 258 + LAT[i]);
      chk($sformatf("cdf_min_L%0d", LAT[i]), cmin[i], v.e_min);
      chk($sformatf("cdf_total_L%0d", LAT[i]), ctot[i], v.e_tot);
      chk($sformatf("overflow_L%0d", LAT[i]), covf[i], v.e_ovf);
      chk($sformatf("cdf_array_L%0d", LAT[i]), mism, 0);
      chk($sformatf("busy_after_L%0d", LAT[i]), busy[i], 0);
    end
    chk($sformatf("cdf[%0d]", v.k0), got[1][v.k0], v.e0);
    chk($sformatf("cdf[%0d]", v.k1), got[1][v.k1], v.e1);
  endtask
  initial begin
    int w;
    int t;
    vt[0] = '{0, 1, 256, 0, 0, 1, 255, 256};
    vt[1] = '{1, 5, 8, 0, 9, 0, 10, 5};
    vt[2] = '{2, 512, 65535, 1, 126, 65024, 127, 65535};
    vt[3] = '{3, 0, 0, 0, 0, 0, 255, 0};
    tick(3);
    chk("rst_ctrl", int'({re[1], we[1], covf[1], busy[1], done[1]}), 0);
    chk("rst_addr", int'({ra[1], wa[1]}), 0);
    chk("rst_data", int'(wd[1] | cmin[1] | ctot[1]), 0);
    reset = 1'b1;
    tick(2);
    for (int v = 0; v < 4; v++) begin
      fill(vt[v].kind);
      pulse();
      wait_done(2, -1);
      check_pass(vt[v]);
      if (v == 1) chk("cdf[255]_sparse", got[1][255], 8);
    end
    fill(0);
    pulse();
    wait_done(2, 49);
    check_pass(vt[0]);
    fill(0);
    pulse();
    tick(99);
    chk("pre_reset_busy", busy[1], 1);
    reset = 1'b0;
    #1;
    chk("arst_ctrl", int'({re[1], we[1], covf[1], busy[1], done[1]}), 0);
    chk("arst_data", int'(wd[1] | cmin[1] | ctot[1]), 0);
    w = nwr[1];
    tick(2);
    reset = 1'b1;
    tick(20);
    chk("arst_no_writes", nwr[1], w);
    chk("arst_no_done", ndone[1], 0);
    chk("arst_idle", int'({re[1], busy[1]}), 0);
    fill(0);
    pulse();
    wait_done(2, -1);
    check_pass(vt[0]);
    fill(0);
    start_cdf = 1'b1;
    t = 0;
    while (!done[1] && t < 400) begin
      tick(1);
      t++;
    end
    if (!done[1]) chk("hold_timeout", 0, 1);
    tick(1);
    chk("hold_idle_busy", busy[1], 0);
    tick(1);
    chk("hold_restart_re", re[1], 1);
    chk("hold_restart_addr", ra[1], 0);
    start_cdf = 1'b0;
    wait_done(1, -1);
    chk("hold_writes", nwr[1], 256);
    chk("hold_total", ctot[1], 256);
    chk("hold_done_pulses", ndone[1], 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/histogram_cdf.md
Name: histogram_cdf

Overview:
Downstream stage of the histogram control block. Once the histogram computation completes, it streams all bin counts out of the scratch memory and accumulates a running cumulative distribution (CDF), writing one CDF entry per bin into the CDF memory. It also reports cdf_min (the first nonzero CDF value) and cdf_total, which the equalization-mapping stage consumes.

Parameters:
NUM_BINS, 256, number of histogram bins read and written
BIN_ADDR_WIDTH, 8, width of bin address (log2 NUM_BINS)
COUNT_WIDTH, 16, width of bin count and CDF value
READ_LATENCY, 2, cycles from scratch read address/enable to valid read data (min 1)

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start_cdf  input  1  level; sampled only in IDLE; normally driven from histogram_computation_done
scratch_mem_read_enable  output  1  read strobe to scratch memory
scratch_mem_read_address  output  BIN_ADDR_WIDTH  bin being read
scratch_mem_read_data  input  COUNT_WIDTH  bin count, valid READ_LATENCY cycles after strobe
cdf_mem_write_enable  output  1  write strobe to CDF memory
cdf_mem_write_address  output  BIN_ADDR_WIDTH  CDF entry index
cdf_mem_write_data  output  COUNT_WIDTH  cumulative value
cdf_min  output  COUNT_WIDTH  first nonzero CDF value; 0 if histogram empty
cdf_total  output  COUNT_WIDTH  final CDF value (total pixel count, saturated)
cdf_overflow  output  1  sticky; the sum saturated during the current pass
cdf_busy  output  1  high from the first ISSUE cycle until DONE inclusive
cdf_computation_done  output  1  one-cycle pulse at pass completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all outputs 0; address counter, running sum and read-valid delay line cleared.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE: if start_cdf=1 at edge S -> ISSUE. Same edge clears running sum, cdf_min, cdf_total, cdf_overflow, and the min_found flag.
- ISSUE: read_enable=1 every cycle; address starts at 0 (cycle S+1) and increments by 1. The cycle that issues address NUM_BINS-1 -> DRAIN. No reads in flight are skipped or repeated.
- The delay line (depth READ_LATENCY) carries valid and address alongside each read. Returned data for address a is valid at cycle S+1+a+READ_LATENCY.
- Accumulate: new_sum = sum + read_data, computed at COUNT_WIDTH+1 bits. If the result exceeds 2^COUNT_WIDTH-1, clamp to all-ones and set cdf_overflow. Once saturated, the sum stays saturated.
- Write is registered: cdf_mem_write_enable=1, address=a, data=new_sum at cycle S+2+a+READ_LATENCY. Enable is high for exactly NUM_BINS cycles, with consecutive addresses.
- cdf_min: latched at the first returned bin whose new_sum is nonzero, then held. Remains 0 if every bin is zero.
- DRAIN: read_enable=0. Stays until the write for NUM_BINS-1 has been asserted, then -> DONE.
- DONE: cdf_computation_done=1 for one cycle (default at S+260); cdf_total=final sum is already stable; -> IDLE.
- cdf_min, cdf_total and cdf_overflow hold their values in IDLE until the next start.
- start_cdf while not IDLE: ignored; no restart and no second pass.
- start_cdf held high through DONE: a new pass starts at the first IDLE cycle.
- Reset asserted mid-pass: immediate abort and outputs to 0. No write strobe is emitted after reset assertion.
- Address counter width is exactly BIN_ADDR_WIDTH and never wraps within a pass.

Decomposition:
- Shared package histogram_pkg holds:
  - NUM_BINS, BIN_ADDR_WIDTH and COUNT_WIDTH defaults, shared with the histogram control block and the mapping stage.
  - The CDF state encoding: IDLE=2'b00, ISSUE=2'b01, DRAIN=2'b10, DONE=2'b11.
- One sub-module, histogram_cdf_read_pipe: a parameterized valid+address delay line of depth READ_LATENCY, with asynchronous active-low clear.
- The FSM, address counter and saturating accumulator stay in histogram_cdf.

Test Plan:
- All bins=1, start pulse at S -> cdf[k]=k+1 for k=0..255; cdf_min=1; cdf_total=256; overflow=0; done pulse at exactly S+260; 256 write strobes with consecutive addresses.
- Bins 0..9=0, bin10=5, bin255=3, others 0 -> cdf[0..9]=0, cdf[10..254]=5, cdf[255]=8; cdf_min=5; cdf_total=8.
- All bins=0x0200 -> cdf[126]=0xFE00; cdf[127..255]=0xFFFF; cdf_overflow=1; cdf_total=0xFFFF.
- All bins=0 -> all cdf=0; cdf_min=0; cdf_total=0; done still pulses once.
- start_cdf re-pulsed at S+50 -> ignored; exactly 256 writes, one done pulse. Then start again after done -> new pass with cleared sum and overflow.
- reset asserted at S+100 for 2 cycles -> all outputs 0 immediately and no further writes. A subsequent start gives a correct full pass (repeat test 1 values); also rerun test 1 with READ_LATENCY=1 and READ_LATENCY=4, expecting done at S+259 and S+262.
